serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 1..32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a subtraction a - b.
REQ-005 The module SHALL have ports a and b, input, WIDTH bits each: the minuend and subtrahend, unsigned, sampled only when a start is accepted.
REQ-006 The module SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-007 The module SHALL have port done, output, 1 bit: a one-cycle pulse marking that the result is complete.
REQ-008 The module SHALL have port diff, output, WIDTH bits: the result a - b mod 2^WIDTH.
REQ-009 The module SHALL have port borrow, output, 1 bit: the final borrow-out, 1 when a < b unsigned.
REQ-010 The module SHALL have ports diff_bit and diff_bit_valid, output, 1 bit each: the serial difference stream, LSB first.

Function
REQ-011 The FSM SHALL have the states IDLE, BUSY and DONE, with IDLE after reset.
REQ-012 IDLE: when start=1, the block SHALL latch a and b into shift registers, clear the internal borrow flop, clear the bit counter and go to BUSY; when start=0 it SHALL stay in IDLE.
REQ-013 BUSY: each cycle the block SHALL compute one bit from the operand LSBs a0, b0 and the borrow-in br, using two chained half subtractors:
  - d = a0^b0^br
  - bout = (~a0&b0) | (~(a0^b0)&br)
REQ-014 BUSY: each cycle the block SHALL shift d into the result register from the MSB end, shift both operands right by one, load bout into the borrow flop and increment the counter.
REQ-015 BUSY: diff_bit SHALL equal d and diff_bit_valid SHALL be 1 in each of the WIDTH BUSY cycles, with bit 0 first.
REQ-016 After exactly WIDTH BUSY cycles the FSM SHALL go to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, diff SHALL hold the full result and borrow SHALL hold the final bout, after which the FSM SHALL return to IDLE.
REQ-018 Latency: for start accepted at edge T, done SHALL be high in the cycle after edge T+WIDTH.
REQ-019 The minimum start-to-start spacing SHALL be WIDTH+2 cycles.
REQ-020 busy SHALL be 1 only in BUSY; done SHALL be 1 only in DONE.
REQ-021 diff and borrow SHALL hold their values from DONE until the next accepted start.
REQ-022 diff SHALL be unspecified while busy=1; the bench SHALL check it only at done.
REQ-023 start SHALL be ignored in BUSY and DONE, and changes on a or b outside an accepted start SHALL have no effect.
REQ-024 With WIDTH=1 the block SHALL produce a single BUSY cycle and then DONE.
REQ-025 Equal operands SHALL yield diff=0 and borrow=0.

Reset
REQ-026 When rst=1 at a clock edge, the FSM SHALL go to IDLE and busy, done, diff, borrow, diff_bit, diff_bit_valid and all internal registers SHALL become 0.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 A reset asserted mid-BUSY SHALL abort the operation with no done pulse, and a start in the first cycle after rst deasserts SHALL be accepted normally.

Configuration
REQ-029 The block SHALL use macro SERIAL_SUBTRACTOR_OVF_EN to compile the signed-overflow output in or out.
REQ-030 With SERIAL_SUBTRACTOR_OVF_EN defined, the block SHALL add output port ovf (1 bit), registered at DONE alongside diff, reset to 0 and held with diff.
REQ-031 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the latched operands, i.e. signed two's-complement overflow.
REQ-032 Without SERIAL_SUBTRACTOR_OVF_EN, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL cover, with WIDTH=8: a=5, b=3, start pulsed -> 8 diff_bit_valid cycles with stream 0,1,0,0,0,0,0,0, then done with diff=0x02 and borrow=0.
REQ-034 The bench SHALL cover: a=3, b=5 -> diff=0xFE, borrow=1; a=0x00, b=0xFF -> diff=0x01, borrow=1; a=b=0xA5 -> diff=0x00, borrow=0.
REQ-035 The bench SHALL cover: start held high for the whole operation with a and b changed mid-BUSY -> exactly one done, with the result from the first-sampled operands and the next operation starting only from IDLE.
REQ-036 The bench SHALL cover: rst=1 at the 4th BUSY cycle -> all outputs 0 the next cycle, no done, and a fresh 7-2 start giving diff=0x05.
REQ-037 The bench SHALL cover, with SERIAL_SUBTRACTOR_OVF_EN defined: 0x80-0x01 -> diff=0x7F, ovf=1; 0x7F-0x01 -> diff=0x7E, ovf=0; without the macro, the same runs SHALL give identical diff and borrow.
REQ-038 The bench SHALL cover, with WIDTH=1: a=0, b=1 -> done 2 cycles after start, diff=1, borrow=1.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result bundle for serial_subtractor; ovf exists only with SERIAL_SUBTRACTOR_OVF_EN.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borrow;
  logic diff_bit;
  logic diff_bit_valid;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf;
  modport master(output start, a, b, input busy, done, diff, borrow, diff_bit, diff_bit_valid, ovf);
  modport slave(input start, a, b, output busy, done, diff, borrow, diff_bit, diff_bit_valid, ovf);
`else
  modport master(output start, a, b, input busy, done, diff, borrow, diff_bit, diff_bit_valid);
  modport slave(input start, a, b, output busy, done, diff, borrow, diff_bit, diff_bit_valid);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first; SERIAL_SUBTRACTOR_OVF_EN adds signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0] cnt;
  logic br, d, bout, last;
  assign d = sa[0] ^ sb[0] ^ br;
  assign bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last = cnt == CW'(WIDTH - 1);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic am, bm, ovf_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      am <= 1'b0;
      bm <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      am <= bus.a[WIDTH-1];
      bm <= bus.b[WIDTH-1];
    end else if (state == BUSY && last) begin
      ovf_r <= (am != bm) && (d != am);
    end
  end
  assign bus.ovf = ovf_r;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      res <= '0;
      cnt <= '0;
      br <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sa <= bus.a;
      sb <= bus.b;
      cnt <= '0;
      br <= 1'b0;
      state <= BUSY;
    end else if (state == BUSY) begin
      res <= WIDTH'({d, res} >> 1);
      sa <= sa >> 1;
      sb <= sb >> 1;
      br <= bout;
      cnt <= cnt + 1'b1;
      state <= last ? DONE : BUSY;
    end else begin
      state <= IDLE;
    end
  end
  assign bus.busy = state == BUSY;
  assign bus.done = state == DONE;
  assign bus.diff = res;
  assign bus.borrow = br;
  assign bus.diff_bit = (state == BUSY) & d;
  assign bus.diff_bit_valid = state == BUSY;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized scoreboard bench for WIDTH=8 and WIDTH=1 serial_subtractor instances.
module tb_serial_subtractor;
  typedef struct {
    logic [7:0] diff;
    logic borrow;
    logic ovf;
  } exp8_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(8)) b8();
  serial_subtractor_if #(.WIDTH(1)) b1();
  serial_subtractor #(.WIDTH(8)) dut8(.clk(clk), .rst(rst), .bus(b8.slave));
  serial_subtractor #(.WIDTH(1)) dut1(.clk(clk), .rst(rst), .bus(b1.slave));
  exp8_t q8[$];
  logic [1:0] q1[$];
  int checks = 0, fails = 0;
  int nbits8 = 0, nbits1 = 0;
  logic [7:0] stream8;
  logic stream1;
  exp8_t em;
  logic [1:0] e1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b);
    exp8_t e;
    int ud = int'(a) - int'(b);
    int sd = (a >= 128 ? int'(a) - 256 : int'(a)) - (b >= 128 ? int'(b) - 256 : int'(b));
    e.diff = 8'(ud + 256);
    e.borrow = ud < 0;
    e.ovf = sd > 127 || sd < -128;
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst) nbits8 = 0;
    else begin
      if (b8.diff_bit_valid) begin
        if (nbits8 < 8) stream8[nbits8] = b8.diff_bit;
        nbits8++;
      end
      if (b8.done) begin
        if (q8.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done8: got done=1, expected no done");
        end else begin
          em = q8.pop_front();
          chk("diff8", b8.diff, em.diff);
          chk("borrow8", b8.borrow, em.borrow);
          chk("stream_len8", nbits8, 8);
          chk("stream8", stream8, em.diff);
          chk("busy_at_done8", b8.busy, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          chk("ovf8", b8.ovf, em.ovf);
`endif
        end
        nbits8 = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (rst) nbits1 = 0;
    else begin
      if (b1.diff_bit_valid) begin
        stream1 = b1.diff_bit;
        nbits1++;
      end
      if (b1.done) begin
        if (q1.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done1: got done=1, expected no done");
        end else begin
          e1 = q1.pop_front();
          chk("diff1", b1.diff, e1[0]);
          chk("borrow1", b1.borrow, e1[1]);
          chk("stream_len1", nbits1, 1);
          chk("stream1", stream1, e1[0]);
        end
        nbits1 = 0;
      end
    end
  end
  task automatic wait_done8(input string name);
    for (int i = 0; i < 20; i++) begin
      if (b8.done) return;
      @(posedge clk);
      #1;
    end
    checks++;
    fails++;
    $display("FAIL timeout_%s: got no done, expected done within 20 cycles", name);
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    exp8_t e = model8(a, b);
    @(posedge clk);
    #1;
    b8.start = 1'b1;
    b8.a = a;
    b8.b = b;
    q8.push_back(e);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20 && !b8.done; i++) begin
      b8.start = 1'($urandom_range(0, 1));
      b8.a = 8'($urandom);
      b8.b = 8'($urandom);
      @(posedge clk);
      #1;
    end
    wait_done8("op8");
    b8.start = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_diff8", b8.diff, e.diff);
    chk("hold_borrow8", b8.borrow, e.borrow);
  endtask
  task automatic op1(input logic a, input logic b);
    @(posedge clk);
    #1;
    b1.start = 1'b1;
    b1.a = a;
    b1.b = b;
    q1.push_back({a < b, a ^ b});
    @(posedge clk);
    #1;
    b1.start = 1'b0;
    chk("busy1_after_start", b1.busy, 1);
    @(posedge clk);
    #1;
    chk("done1_latency", b1.done, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    b8.start = 1'b0;
    b8.a = '0;
    b8.b = '0;
    b1.start = 1'b0;
    b1.a = '0;
    b1.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", b8.busy, 0);
    chk("rst_done8", b8.done, 0);
    chk("rst_diff8", b8.diff, 0);
    chk("rst_borrow8", b8.borrow, 0);
    chk("rst_dbv8", b8.diff_bit_valid, 0);
    chk("rst_busy1", b1.busy, 0);
    rst = 1'b0;
    op8(8'h05, 8'h03);
    op8(8'h03, 8'h05);
    op8(8'h00, 8'hFF);
    op8(8'hA5, 8'hA5);
    op8(8'h80, 8'h01);
    op8(8'h7F, 8'h01);
    op8(8'hFF, 8'h00);
    for (int i = 0; i < 40; i++) op8(8'($urandom), 8'($urandom));
    // start held high across a whole operation while operands change mid-BUSY
    @(posedge clk);
    #1;
    b8.start = 1'b1;
    b8.a = 8'h40;
    b8.b = 8'h11;
    q8.push_back(model8(8'h40, 8'h11));
    repeat (3) @(posedge clk);
    #1;
    b8.a = 8'h09;
    b8.b = 8'h30;
    wait_done8("held");
    q8.push_back(model8(8'h09, 8'h30));
    @(posedge clk);
    #1;
    chk("idle_gap_busy8", b8.busy, 0);
    chk("idle_gap_done8", b8.done, 0);
    @(posedge clk);
    #1;
    chk("restart_busy8", b8.busy, 1);
    b8.start = 1'b0;
    wait_done8("held2");
    @(posedge clk);
    #1;
    // reset on the 4th BUSY cycle aborts without done
    b8.start = 1'b1;
    b8.a = 8'h33;
    b8.b = 8'h11;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy8", b8.busy, 0);
    chk("abort_done8", b8.done, 0);
    chk("abort_diff8", b8.diff, 0);
    chk("abort_borrow8", b8.borrow, 0);
    chk("abort_bit8", b8.diff_bit, 0);
    chk("abort_dbv8", b8.diff_bit_valid, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("abort_ovf8", b8.ovf, 0);
`endif
    rst = 1'b0;
    b8.start = 1'b1;
    b8.a = 8'h07;
    b8.b = 8'h02;
    q8.push_back(model8(8'h07, 8'h02));
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    wait_done8("post_rst");
    @(posedge clk);
    #1;
    op1(1'b0, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b1, 1'b1);
    op1(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
